uart_core: RTL and testbench
============================

Name: uart_core

Overview:
Byte-oriented full-duplex UART, fixed 8N1 framing, for the Basys3 design. Sits between the board-level serial pins (uart_rxd/uart_txd) and fabric logic. Fabric logic exchanges bytes through two valid/ready streams, each buffered by a small FIFO. Clock and reset come from the system clock/reset generator, channel 0.

Parameters:
CLK_FREQ, 100000000, clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
FIFO_DEPTH, 16, entries in each of the RX and TX FIFOs; must be a power of 2.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-low reset.
uart_rd_data  out  8  received byte at the RX FIFO head.
uart_rd_valid  out  1  RX FIFO not empty.
uart_rd_ready  in  1  consumer accepts uart_rd_data.
uart_wr_data  in  8  byte to transmit.
uart_wr_valid  in  1  uart_wr_data is valid.
uart_wr_ready  out  1  TX FIFO not full.
uart_mode  in  2  00 normal; 01 internal loopback; 10/11 reserved, behave as 00.
uart_rxd  in  1  serial input, idle high, asynchronous to clk.
uart_txd  out  1  serial output, idle high.

Behaviour:
- Bit period: BIT_CYC = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, giving 868 at the defaults. HALF_CYC = BIT_CYC/2, giving 434.
- Reset (rst=0): all state cleared immediately. Outputs: uart_txd=1, uart_rd_valid=0, uart_rd_data=0, uart_wr_ready=0. uart_wr_ready rises on the first clk after rst deasserts.
- Reset mid-frame aborts both frames in progress and empties both FIFOs.
- Stream handshakes: a transfer occurs on a clk edge where valid && ready.
  - Writes while uart_wr_ready=0 are ignored.
  - uart_rd_data is stable while uart_rd_valid=1 and no pop occurs.
- RX input path: uart_rxd passes through a 2-flop synchronizer. In mode 01 the RX path instead takes the internal TX serial stream, and uart_txd is held at 1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: on a synchronized falling edge go to START and load the counter with HALF_CYC.
  - START: at mid-bit, if the line is still 0 go to DATA. Otherwise it is a false start; return to IDLE.
  - DATA: sample every BIT_CYC at mid-bit, 8 bits, LSB first.
  - STOP: at mid stop bit:
    - line=1: push the byte, return to IDLE.
    - line=0: framing error; discard the byte and wait in STOP until the line is high before returning to IDLE.
- RX FIFO: the push happens on the mid-stop-bit sample cycle, and uart_rd_valid is asserted by the following clk. If the FIFO is full the new byte is dropped (overrun) and the FIFO contents are unchanged. A simultaneous push and pop on a full FIFO is accepted.
- TX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: if the TX FIFO is not empty, pop one byte and drive the start bit (0) on the next clk.
  - Frame: start bit, then 8 data bits LSB first, then stop bit (1), each held exactly BIT_CYC clocks.
  - After the stop bit, if the FIFO is not empty, the next start bit follows with no idle gap; otherwise return to IDLE.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide. Full = MSBs differ and the rest are equal; empty = equal. Pointers wrap modulo 2*FIFO_DEPTH.
- A change of uart_mode takes effect at the next frame boundary.

Decomposition:
- Package uart_core_pkg holds:
  - bit-period helper function and localparams BIT_CYC and HALF_CYC;
  - mode enum: UART_MODE_NORMAL=2'b00, UART_MODE_LOOPBACK=2'b01;
  - rx_state_t and tx_state_t enums.
- One sub-module, uart_fifo: a synchronous FWFT FIFO with parameters WIDTH and DEPTH, instantiated twice (RX and TX).
- RX and TX FSMs are written inline in uart_core.

Test Plan:
- Reset and idle: rst=0 for 10 clks -> txd=1, rd_valid=0, wr_ready=0. Release rst -> wr_ready=1 within 1 clk.
- Single byte: drive 0xA5 as 8N1 at 8680 ns/bit, rd_ready=1 -> one rd transfer with rd_data=0xA5, and rd_valid asserted within 2 clks of mid stop bit.
- Stream: 128 random bytes back-to-back, rd_ready=1 -> all 128 captured in order, no loss.
- Overrun and glitch:
  - rd_ready=0, send 17 bytes 0x00..0x10 -> 16 retained (0x00..0x0F); 0x10 dropped.
  - A 200 ns low glitch on rxd -> no byte.
  - A stop bit of 0 -> no byte.
- Transmit: write 0x3C -> txd = 0, 0,0,1,1,1,1,0,0, 1, each level held 868 clks. Two queued bytes are sent with no idle gap between frames.
- Loopback: mode=01, write 0x5A -> rd_data=0x5A, uart_txd stays 1. Asserting rst mid-frame -> txd=1 immediately, both FIFOs empty.

Source files
------------

// File: rtl/uart_core_pkg.sv
// rtl/uart_core_pkg.sv - shared bit timing, mode codes and FSM state types for uart_core
package uart_core_pkg;

  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  localparam int BIT_CYC  = bit_cycles(100000000, 115200);
  localparam int HALF_CYC = BIT_CYC / 2;

  typedef enum logic [1:0] {
    UART_MODE_NORMAL   = 2'b00,
    UART_MODE_LOOPBACK = 2'b01
  } uart_mode_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through FIFO; extra pointer MSB separates full from empty
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // a pop frees the head slot this same edge, so a full FIFO can still take a push
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 full-duplex UART with FIFO-buffered byte streams and internal loopback
module uart_core
  import uart_core_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] uart_rd_data,
  output logic       uart_rd_valid,
  input  logic       uart_rd_ready,
  input  logic [7:0] uart_wr_data,
  input  logic       uart_wr_valid,
  output logic       uart_wr_ready,
  input  logic [1:0] uart_mode,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int BIT_N  = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_N = BIT_N / 2;
  localparam int CW     = $clog2(BIT_N);

  logic          rxd_s1, rxd_s2, rx_prev, rx_line;
  logic          lb_q, rst_done;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sr;
  logic          rx_ferr, rx_push, rx_pop, rx_full, rx_empty;
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sr, tx_byte;
  logic          tx_line, tx_pop, tx_full, tx_empty;

  assign rx_line       = lb_q ? tx_line : rxd_s2;
  assign uart_txd      = lb_q ? 1'b1 : tx_line;
  assign uart_rd_valid = !rx_empty;
  assign uart_wr_ready = rst_done && !tx_full;
  assign rx_pop        = uart_rd_valid && uart_rd_ready;
  assign rx_push       = (rx_state == RX_STOP) && !rx_ferr && (rx_cnt == '0) && rx_line
                         && (!rx_full || rx_pop);
  assign tx_pop        = !tx_empty && ((tx_state == TX_IDLE) ||
                                       ((tx_state == TX_STOP) && (tx_cnt == '0)));

  // loopback selection only changes while both directions sit between frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rx_prev  <= 1'b1;
      lb_q     <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rx_prev  <= rx_line;
      rst_done <= 1'b1;
      if (rx_state == RX_IDLE && tx_state == TX_IDLE)
        lb_q <= (uart_mode == UART_MODE_LOOPBACK);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sr    <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_line) begin
          rx_state <= RX_START;
          rx_cnt   <= CW'(HALF_N - 1);
        end
        RX_START: if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else if (!rx_line) begin
            rx_state <= RX_DATA;
            rx_cnt   <= CW'(BIT_N - 1);
            rx_bit   <= '0;
          end else rx_state <= RX_IDLE;
        RX_DATA: if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else begin
            rx_sr  <= {rx_line, rx_sr[7:1]};
            rx_cnt <= CW'(BIT_N - 1);
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        // a low stop bit is a framing error: hold here until the line recovers
        RX_STOP: if (rx_ferr) begin
            if (rx_line) begin
              rx_ferr  <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else if (rx_line) rx_state <= RX_IDLE;
          else rx_ferr <= 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sr    <= '0;
      tx_line  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_sr    <= tx_byte;
      tx_line  <= 1'b0;
      tx_cnt   <= CW'(BIT_N - 1);
    end else begin
      case (tx_state)
        TX_START: if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
          else begin
            tx_state <= TX_DATA;
            tx_line  <= tx_sr[0];
            tx_sr    <= {1'b0, tx_sr[7:1]};
            tx_cnt   <= CW'(BIT_N - 1);
            tx_bit   <= '0;
          end
        TX_DATA: if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
          else begin
            tx_cnt <= CW'(BIT_N - 1);
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              tx_line <= tx_sr[0];
              tx_sr   <= {1'b0, tx_sr[7:1]};
            end
          end
        TX_STOP: if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
          else tx_state <= TX_IDLE;
        default: ;
      endcase
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_sr),
    .pop       (rx_pop),
    .pop_data  (uart_rd_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (uart_wr_valid && uart_wr_ready),
    .push_data (uart_wr_data),
    .pop       (tx_pop),
    .pop_data  (tx_byte),
    .full      (tx_full),
    .empty     (tx_empty)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed bench: dut0 at the default 868-clk bit, dut1 at a 16-clk bit
module tb_uart_core;

  localparam int B0 = 868;
  localparam int B1 = 16;

  logic       clk, rst;
  logic [7:0] rd_data0, rd_data1, wr_data0, wr_data1;
  logic       rd_valid0, rd_valid1, rd_ready0, rd_ready1;
  logic       wr_valid0, wr_valid1, wr_ready0, wr_ready1;
  logic [1:0] mode0, mode1;
  logic       rxd0, rxd1, txd0, txd1;

  int         n_checks = 0;
  int         n_pass = 0;
  int         lat, run, errs, n;
  logic       lo;
  logic [7:0] v;
  logic [19:0] obs;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] expq[$];

  uart_core u_dut0 (
    .clk(clk), .rst(rst),
    .uart_rd_data(rd_data0), .uart_rd_valid(rd_valid0), .uart_rd_ready(rd_ready0),
    .uart_wr_data(wr_data0), .uart_wr_valid(wr_valid0), .uart_wr_ready(wr_ready0),
    .uart_mode(mode0), .uart_rxd(rxd0), .uart_txd(txd0)
  );

  uart_core #(.CLK_FREQ(100000000), .BAUD_RATE(6250000), .FIFO_DEPTH(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .uart_rd_data(rd_data1), .uart_rd_valid(rd_valid1), .uart_rd_ready(rd_ready1),
    .uart_wr_data(wr_data1), .uart_wr_valid(wr_valid1), .uart_wr_ready(wr_ready1),
    .uart_mode(mode1), .uart_rxd(rxd1), .uart_txd(txd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid0 && rd_ready0) q0.push_back(rd_data0);
      if (rd_valid1 && rd_ready1) q1.push_back(rd_data1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop, input int bc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) rxd1 = f[i]; else rxd0 = f[i];
      step(bc);
    end
    if (sel) rxd1 = 1'b1; else rxd0 = 1'b1;
  endtask

  task automatic write_byte(input bit sel, input logic [7:0] b);
    int k;
    k = 0;
    if (sel) begin wr_data1 = b; wr_valid1 = 1'b1; end
    else     begin wr_data0 = b; wr_valid0 = 1'b1; end
    while (!(sel ? wr_ready1 : wr_ready0) && k < 100) begin step(1); k++; end
    if (k >= 100) check("wr_ready_timeout", 32'(k), 0);
    step(1);
    if (sel) wr_valid1 = 1'b0; else wr_valid0 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rxd0 = 1'b1; rxd1 = 1'b1;
    rd_ready0 = 1'b0; rd_ready1 = 1'b0;
    wr_data0 = '0; wr_data1 = '0; wr_valid0 = 1'b0; wr_valid1 = 1'b0;
    mode0 = 2'b00; mode1 = 2'b00;
    step(10);
    check("rst_txd", txd0, 1);
    check("rst_rd_valid", rd_valid0, 0);
    check("rst_wr_ready", wr_ready0, 0);
    check("rst_rd_data", rd_data0, 0);
    rst = 1'b1;
    step(1);
    check("wr_ready_after_rst0", wr_ready0, 1);
    check("wr_ready_after_rst1", wr_ready1, 1);

    // single byte at 868 clks/bit; stop-bit midpoint sits 8246 clks after the start edge
    rd_ready0 = 1'b1;
    q0.delete();
    fork
      send_frame(0, 8'hA5, 1'b1, B0);
      begin
        lat = 0;
        while (!rd_valid0 && lat < 9500) begin step(1); lat++; end
      end
    join
    check("rx_latency_window", 32'(lat >= 8246 && lat <= 8251), 1);
    check("rx_single_count", q0.size(), 1);
    v = (q0.size() > 0) ? q0[0] : 8'h00;
    check("rx_single_data", v, 8'hA5);

    q0.delete();
    rxd0 = 1'b0; step(20); rxd0 = 1'b1;
    step(1000);
    check("glitch_no_byte", q0.size(), 0);
    check("glitch_rd_valid", rd_valid0, 0);

    // 0x3C framed: 0 | 0 0 1 1 1 1 0 0 | 1 -> runs of 3 low, 4 high, 2 low bits
    write_byte(0, 8'h3C);
    n = 0;
    while (txd0 && n < 20) begin step(1); n++; end
    check("tx_start_seen", txd0, 0);
    run = 0;
    while (!txd0 && run < 5000) begin step(1); run++; end
    check("tx_run_lo3", run, 3 * B0);
    run = 0;
    while (txd0 && run < 5000) begin step(1); run++; end
    check("tx_run_hi4", run, 4 * B0);
    run = 0;
    while (!txd0 && run < 5000) begin step(1); run++; end
    check("tx_run_lo2", run, 2 * B0);
    run = 0;
    while (txd0 && run < 2 * B0) begin step(1); run++; end
    check("tx_stop_idle", run, 2 * B0);

    rd_ready1 = 1'b1;
    q1.delete();
    expq.delete();
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom_range(0, 255));
      expq.push_back(v);
      send_frame(1, v, 1'b1, B1);
    end
    step(3 * B1);
    check("stream_count", q1.size(), 128);
    errs = 0;
    for (int i = 0; i < expq.size(); i++)
      if (i >= q1.size() || q1[i] !== expq[i]) errs++;
    check("stream_data", errs, 0);

    rd_ready1 = 1'b0;
    q1.delete();
    for (int i = 0; i < 17; i++) send_frame(1, 8'(i), 1'b1, B1);
    step(2 * B1);
    check("ovr_rd_valid", rd_valid1, 1);
    check("ovr_head", rd_data1, 8'h00);
    rd_ready1 = 1'b1;
    step(40);
    check("ovr_count", q1.size(), 16);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (i >= q1.size() || q1[i] !== 8'(i)) errs++;
    check("ovr_data", errs, 0);

    q1.delete();
    send_frame(1, 8'h77, 1'b0, B1);
    step(3 * B1);
    check("ferr_no_byte", q1.size(), 0);
    send_frame(1, 8'h12, 1'b1, B1);
    step(2 * B1);
    v = (q1.size() > 0) ? q1[0] : 8'h00;
    check("ferr_recover", v, 8'h12);

    // 0xFF then 0x81 back to back: frames 10'h3FE and 10'h302, bit 0 first
    write_byte(1, 8'hFF);
    write_byte(1, 8'h81);
    n = 0;
    while (txd1 && n < 20) begin step(1); n++; end
    obs = '0;
    step(B1 / 2);
    for (int i = 0; i < 20; i++) begin
      obs[i] = txd1;
      step(B1);
    end
    check("tx_back_to_back", obs, 20'hC0BFE);

    mode1 = 2'b01;
    step(3);
    q1.delete();
    write_byte(1, 8'h5A);
    n = 0; lo = 1'b0;
    while (q1.size() == 0 && n < 400) begin
      if (!txd1) lo = 1'b1;
      step(1); n++;
    end
    v = (q1.size() > 0) ? q1[0] : 8'h00;
    check("lb_data", v, 8'h5A);
    check("lb_txd_high", lo, 0);

    mode1 = 2'b00;
    step(3);
    rd_ready1 = 1'b0;
    q1.delete();
    send_frame(1, 8'h44, 1'b1, B1);
    step(B1);
    check("pre_rst_rd_valid", rd_valid1, 1);
    write_byte(1, 8'h01);
    write_byte(1, 8'h02);
    write_byte(1, 8'h03);
    n = 0;
    while (txd1 && n < 20) begin step(1); n++; end
    step(5);
    check("pre_rst_txd_low", txd1, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_txd", txd1, 1);
    check("rst_mid_rd_valid", rd_valid1, 0);
    check("rst_mid_wr_ready", wr_ready1, 0);
    step(3);
    rst = 1'b1;
    step(1);
    check("rst_mid_wr_ready_back", wr_ready1, 1);
    lo = 1'b0;
    for (int i = 0; i < 3 * B1; i++) begin
      if (!txd1) lo = 1'b1;
      step(1);
    end
    check("rst_tx_fifo_empty", lo, 0);
    check("rst_rx_fifo_empty", rd_valid1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
